// File: rtl/mem_arbiter.sv
// Shares one memory bus between instruction fetch and data access; data has priority, bounded by a streak limit.
// Latency: grant registers onto the bus one edge after the IDLE decision; the ack/err is forwarded combinationally.
// Backpressure: a requester holds its request until ack/err; a loser simply waits in IDLE for a later grant.
module mem_arbiter #(
    parameter int AddrWidth     = 32,
    parameter int DataWidth     = 32,
    parameter int MaxDataStreak = 4,
    parameter int TimeoutCycles = 256
) (
    input  logic                   iClk,
    input  logic                   iRst,
    input  logic                   iIReq,
    input  logic [AddrWidth-1:0]   iIAddr,
    input  logic                   iIFlush,
    output logic                   oIAck,
    output logic [DataWidth-1:0]   oIRData,
    output logic                   oIErr,
    input  logic                   iDReq,
    input  logic                   iDWe,
    input  logic [AddrWidth-1:0]   iDAddr,
    input  logic [DataWidth-1:0]   iDWData,
    input  logic [DataWidth/8-1:0] iDBe,
    output logic                   oDAck,
    output logic [DataWidth-1:0]   oDRData,
    output logic                   oDErr,
    output logic                   oMemReq,
    output logic                   oMemWe,
    output logic [AddrWidth-1:0]   oMemAddr,
    output logic [DataWidth-1:0]   oMemWData,
    output logic [DataWidth/8-1:0] oMemBe,
    input  logic                   iMemAck,
    input  logic [DataWidth-1:0]   iMemRData
);

    localparam int BeWidth = DataWidth / 8;
    localparam int StreakW = (MaxDataStreak > 0) ? $clog2(MaxDataStreak + 1) : 1;
    localparam int TimerW  = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [StreakW-1:0] StreakMax = StreakW'(MaxDataStreak);
    localparam logic [TimerW-1:0]  TimerLast = (TimeoutCycles > 0) ? TimerW'(TimeoutCycles - 1) : '0;
    localparam bit TimeoutEn = (TimeoutCycles > 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [StreakW-1:0] streak;
    logic [TimerW-1:0]  timer;
    logic               squash;
    logic               grant_i;
    logic               grant_d;
    logic               timeout_hit;
    logic               done;
    logic               busy;

    assign busy    = (state != IDLE);
    assign oIRData = iMemRData;
    assign oDRData = iMemRData;

    // Grant decision, completion detection and response pulses.
    always_comb begin
        state_nxt   = state;
        grant_i     = 1'b0;
        grant_d     = 1'b0;
        timeout_hit = 1'b0;
        done        = 1'b0;
        oIAck       = 1'b0;
        oIErr       = 1'b0;
        oDAck       = 1'b0;
        oDErr       = 1'b0;
        case (state)
            IDLE: begin
                // Data wins unless fetch has been waiting through a full streak.
                if (iDReq && (!iIReq || (streak < StreakMax))) begin
                    grant_d   = 1'b1;
                    state_nxt = BUSY_D;
                end else if (iIReq) begin
                    grant_i   = 1'b1;
                    state_nxt = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                // An ack arriving on the last allowed cycle takes precedence over the timeout.
                timeout_hit = TimeoutEn && !iMemAck && (timer == TimerLast);
                done        = iMemAck || timeout_hit;
                if (done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // A flush in the completing cycle already hides that fetch's response.
        if (state == BUSY_I && !squash && !iIFlush && !iRst) begin
            oIAck = iMemAck;
            oIErr = timeout_hit;
        end
        if (state == BUSY_D && !iRst) begin
            oDAck = iMemAck;
            oDErr = timeout_hit;
        end
    end

    // State register.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Bus outputs: captured from the winner on the grant edge, held until completion.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            oMemReq   <= 1'b0;
            oMemWe    <= 1'b0;
            oMemAddr  <= '0;
            oMemWData <= '0;
            oMemBe    <= '0;
        end else if (grant_d) begin
            oMemReq   <= 1'b1;
            oMemWe    <= iDWe;
            oMemAddr  <= iDAddr;
            oMemWData <= iDWe ? iDWData : '0;
            oMemBe    <= iDWe ? iDBe : {BeWidth{1'b1}};
        end else if (grant_i) begin
            oMemReq   <= 1'b1;
            oMemWe    <= 1'b0;
            oMemAddr  <= iIAddr;
            oMemWData <= '0;
            oMemBe    <= {BeWidth{1'b1}};
        end else if (done) begin
            oMemReq   <= 1'b0;
        end
    end

    // Consecutive data grants made while fetch waits; any fetch-idle cycle resets it.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            streak <= '0;
        end else if (!iIReq || grant_i) begin
            streak <= '0;
        end else if (grant_d && (streak != StreakMax)) begin
            streak <= streak + StreakW'(1);
        end
    end

    // Cycles spent waiting for the bus ack in the current transaction.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            timer <= '0;
        end else if (grant_i || grant_d) begin
            timer <= '0;
        end else if (busy && !iMemAck) begin
            timer <= timer + TimerW'(1);
        end
    end

    // Remembers that the in-flight fetch was flushed so its late response is dropped.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            squash <= 1'b0;
        end else if (done) begin
            squash <= 1'b0;
        end else if (state == BUSY_I && iIFlush) begin
            squash <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus randomized bench for mem_arbiter with a transaction-level reference model.
// Latency: checks grant on the edge after IDLE and responses in the bus-ack/timeout cycle.
// Backpressure: requesters hold until completion; the loser stays pending for a later grant.
module tb_mem_arbiter;

    localparam int MAXS = 4;
    localparam int TO   = 8;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iIReq;
    logic [31:0] iIAddr;
    logic        iIFlush;
    logic        oIAck;
    logic [31:0] oIRData;
    logic        oIErr;
    logic        iDReq;
    logic        iDWe;
    logic [31:0] iDAddr;
    logic [31:0] iDWData;
    logic [3:0]  iDBe;
    logic        oDAck;
    logic [31:0] oDRData;
    logic        oDErr;
    logic        oMemReq;
    logic        oMemWe;
    logic [31:0] oMemAddr;
    logic [31:0] oMemWData;
    logic [3:0]  oMemBe;
    logic        iMemAck;
    logic [31:0] iMemRData;

    int n_tests = 0;
    int n_fail  = 0;
    int streak_m = 0;

    mem_arbiter #(
        .AddrWidth(32),
        .DataWidth(32),
        .MaxDataStreak(MAXS),
        .TimeoutCycles(TO)
    ) dut (
        .iClk(iClk), .iRst(iRst),
        .iIReq(iIReq), .iIAddr(iIAddr), .iIFlush(iIFlush),
        .oIAck(oIAck), .oIRData(oIRData), .oIErr(oIErr),
        .iDReq(iDReq), .iDWe(iDWe), .iDAddr(iDAddr), .iDWData(iDWData), .iDBe(iDBe),
        .oDAck(oDAck), .oDRData(oDRData), .oDErr(oDErr),
        .oMemReq(oMemReq), .oMemWe(oMemWe), .oMemAddr(oMemAddr),
        .oMemWData(oMemWData), .oMemBe(oMemBe),
        .iMemAck(iMemAck), .iMemRData(iMemRData)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One arbitration round: IDLE decision cycle, then BUSY cycles until ack, timeout or reset.
    // lat = BUSY cycle carrying the bus ack (> TO means never), flush_at/rst_at = BUSY cycle (0 = none).
    task automatic do_txn(input bit i_on, input bit d_on, input logic [31:0] ia,
                          input bit dwe, input logic [31:0] da, input logic [31:0] dw,
                          input logic [3:0] dbe, input int lat, input int flush_at,
                          input int rst_at, input bit idle_ack, input logic [31:0] rdata,
                          output bit obs_i, output bit win_i);
        bit win_d, any, squashed, exp_ack, exp_err, fin, rsp_ok, ewe;
        logic [31:0] ea, ew;
        logic [3:0]  eb;
        iIReq = i_on; iDReq = d_on; iIAddr = ia; iDWe = dwe; iDAddr = da;
        iDWData = dw; iDBe = dbe; iRst = 1'b0;
        iMemAck = idle_ack; iMemRData = $urandom; iIFlush = 1'($urandom_range(0, 1));
        #2;
        check("idle_resp", 64'({oIAck, oIErr, oDAck, oDErr}), 64'(0));
        any   = i_on || d_on;
        win_d = d_on && (!i_on || streak_m < MAXS);
        win_i = any && !win_d;
        if (!i_on || win_i) streak_m = 0;
        else if (streak_m < MAXS) streak_m++;
        obs_i = 1'b0;
        @(posedge iClk); #1;
        iMemAck = 1'b0; iIFlush = 1'b0;
        if (!any) begin
            check("idle_nogrant", 64'(oMemReq), 64'(0));
            return;
        end
        ea  = win_i ? ia : da;
        ewe = win_d && dwe;
        ew  = ewe ? dw : 32'h0;
        eb  = ewe ? dbe : 4'hF;
        obs_i = (oMemAddr === ia);
        squashed = 1'b0;
        for (int k = 1; k <= TO; k++) begin
            iMemAck   = (k == lat);
            iMemRData = (k == lat) ? rdata : $urandom;
            iIFlush   = (k == flush_at);
            iRst      = (k == rst_at);
            #2;
            if (win_i && k == flush_at) squashed = 1'b1;
            rsp_ok  = (k != rst_at);
            exp_ack = (k == lat);
            exp_err = (k == TO) && (lat > TO);
            fin     = exp_ack || exp_err || !rsp_ok;
            check("bus_req", 64'(oMemReq), 64'(1));
            check("bus_addr", 64'(oMemAddr), 64'(ea));
            check("bus_we", 64'(oMemWe), 64'(ewe));
            check("bus_wdata", 64'(oMemWData), 64'(ew));
            check("bus_be", 64'(oMemBe), 64'(eb));
            check("i_ack", 64'(oIAck), 64'(win_i && exp_ack && !squashed && rsp_ok));
            check("i_err", 64'(oIErr), 64'(win_i && exp_err && !squashed && rsp_ok));
            check("d_ack", 64'(oDAck), 64'(win_d && exp_ack && rsp_ok));
            check("d_err", 64'(oDErr), 64'(win_d && exp_err && rsp_ok));
            if (exp_ack && win_i && !squashed) check("i_rdata", 64'(oIRData), 64'(rdata));
            if (exp_ack && win_d) check("d_rdata", 64'(oDRData), 64'(rdata));
            @(posedge iClk); #1;
            if (fin) break;
        end
        iMemAck = 1'b0; iIFlush = 1'b0; iRst = 1'b0;
        check("bus_release", 64'(oMemReq), 64'(0));
        if (rst_at > 0) begin
            check("rst_addr", 64'(oMemAddr), 64'(0));
            streak_m = 0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit obs_i, w;
        bit exp_order [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        bit i_pend, d_pend, r_we;
        logic [31:0] r_ia, r_da, r_dw;
        logic [3:0]  r_be;

        iRst = 1'b1; iIReq = 0; iIAddr = 0; iIFlush = 0; iDReq = 0; iDWe = 0;
        iDAddr = 0; iDWData = 0; iDBe = 0; iMemAck = 0; iMemRData = 0;
        repeat (2) @(posedge iClk);
        #1;
        check("rst_memreq", 64'(oMemReq), 64'(0));
        check("rst_memwe", 64'(oMemWe), 64'(0));
        check("rst_memaddr", 64'(oMemAddr), 64'(0));
        check("rst_memwdata", 64'(oMemWData), 64'(0));
        check("rst_membe", 64'(oMemBe), 64'(0));
        check("rst_resp", 64'({oIAck, oIErr, oDAck, oDErr}), 64'(0));
        streak_m = 0;

        // Single fetch acked in the first BUSY cycle.
        do_txn(1, 0, 32'h100, 0, 0, 0, 0, 1, 0, 0, 0, 32'h13, obs_i, w);
        check("single_fetch_port", 64'(obs_i), 64'(1));

        // Contention: both held, fetch gets one grant after every 4 data grants.
        for (int n = 0; n < 10; n++) begin
            do_txn(1, 1, 32'h200, 0, 32'h8000_0400, 0, 0, 1, 0, 0, 0, $urandom, obs_i, w);
            check("contention_order", 64'(obs_i), 64'(exp_order[n]));
        end

        // Store held on the bus through 5 wait cycles, acked in the 6th.
        do_txn(0, 1, 0, 1, 32'h2004, 32'hDEADBEEF, 4'b0011, 6, 0, 0, 0, 0, obs_i, w);

        // Timeout with no ack, then ack exactly on the last allowed cycle.
        do_txn(1, 0, 32'h300, 0, 0, 0, 0, 99, 0, 0, 0, 0, obs_i, w);
        do_txn(1, 0, 32'h304, 0, 0, 0, 0, TO, 0, 0, 0, 32'h1234_5678, obs_i, w);

        // Flushed fetch: ack suppressed, then a data request is granted.
        do_txn(1, 0, 32'h400, 0, 0, 0, 0, 4, 2, 0, 0, 32'h55, obs_i, w);
        do_txn(0, 1, 0, 0, 32'h8000_0010, 0, 0, 1, 0, 0, 0, 32'hA5A5_0001, obs_i, w);
        check("post_flush_dgrant", 64'(obs_i), 64'(0));

        // Reset in wait cycle 2 of a data access that pushed the streak to its limit.
        for (int n = 0; n < 3; n++)
            do_txn(1, 1, 32'h500, 0, 32'h8000_0500, 0, 0, 1, 0, 0, 0, $urandom, obs_i, w);
        do_txn(1, 1, 32'h500, 0, 32'h8000_0504, 0, 0, 99, 0, 2, 0, 0, obs_i, w);
        check("rst_victim_was_d", 64'(obs_i), 64'(0));
        do_txn(1, 1, 32'h600, 0, 32'h8000_0600, 0, 0, 1, 0, 0, 1, $urandom, obs_i, w);
        check("post_rst_streak_clear", 64'(obs_i), 64'(0));

        // Randomized traffic against the model.
        i_pend = 0; d_pend = 0;
        r_ia = 0; r_da = 0; r_dw = 0; r_be = 0; r_we = 0;
        for (int t = 0; t < 80; t++) begin
            if (!i_pend && $urandom_range(0, 1) == 1) begin
                i_pend = 1;
                r_ia = $urandom & 32'h7FFF_FFFC;
            end
            if (!d_pend && $urandom_range(0, 2) != 0) begin
                d_pend = 1;
                r_da = $urandom | 32'h8000_0000;
                r_we = 1'($urandom_range(0, 1));
                r_dw = $urandom;
                r_be = 4'($urandom_range(0, 15));
            end
            do_txn(i_pend, d_pend, r_ia, r_we, r_da, r_dw, r_be,
                   $urandom_range(1, 10), $urandom_range(0, 6), 0,
                   1'($urandom_range(0, 1)), $urandom, obs_i, w);
            if (i_pend || d_pend) begin
                check("rand_winner", 64'(obs_i), 64'(w));
                if (w) i_pend = 0;
                else d_pend = 0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
